// File: rtl/rom_dl_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_dl_sequencer_if
//   The hps_io ioctl download stream as seen by the ROM download sequencer.
//   master : the download source (hps_io, or a testbench) drives the stream
//   slave  : rom_dl_sequencer consumes it
// Signals
//   ioctl_download  download in progress
//   ioctl_wr        byte strobe, one cycle per byte
//   ioctl_addr      byte address within the current index
//   ioctl_dout      byte data
//   ioctl_index     download index: 0=ROM, 1=variant, 254=DIP
// ---------------------------------------------------------------------------
interface rom_dl_sequencer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    output ioctl_index
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_dout,
    input ioctl_index
  );
endinterface

// File: rtl/rom_dl_sequencer.sv
// ---------------------------------------------------------------------------
// rom_dl_sequencer
//   Sequences the HPS ioctl download stream into the core's loadable
//   resources: index-0 bytes become single-cycle write strobes into the main
//   CPU, sound and wave ROM dprams; index 1 latches the game variant; index
//   254 fills the DIP byte array. dkong_top is held in reset until a complete
//   ROM set has been received and a settle interval has expired.
// Parameters
//   SND_BASE    first byte address of the 4 KiB sound ROM region
//   WAV_BASE    first byte address of the 64 KiB wave ROM region
//   SETTLE_CYC  clk_sys cycles core reset is held after a download ends (>=1)
// Ports
//   clk_sys     system clock
//   reset       synchronous, active-high reset
//   dl          ioctl download stream (slave side)
//   wr_addr     registered dpram write address, region-relative
//   wr_data     registered dpram write data
//   main_we     main ROM write strobe   (0x0000-0x7FFF)
//   snd_we      sound ROM write strobe  (SND_BASE..SND_BASE+0xFFF)
//   wav_we      wave ROM write strobe   (WAV_BASE..WAV_BASE+0xFFFF)
//   game_mod    one-hot {pestplace,radarscope,dk3,dkjr,dk}
//   dip_sw      DIP byte 0
//   core_reset  reset for dkong_top
//   loaded      a complete ROM set has been received
//   err_oob     sticky: an index-0 byte fell outside all regions
//   byte_cnt    index-0 bytes accepted in the current/last load
// ---------------------------------------------------------------------------
module rom_dl_sequencer #(
  parameter logic [24:0] SND_BASE   = 25'h0E000,
  parameter logic [24:0] WAV_BASE   = 25'h10000,
  parameter int unsigned SETTLE_CYC = 1024
) (
  input  logic                clk_sys,
  input  logic                reset,
  rom_dl_sequencer_if.slave   dl,
  output logic [15:0]         wr_addr,
  output logic [7:0]          wr_data,
  output logic                main_we,
  output logic                snd_we,
  output logic                wav_we,
  output logic [4:0]          game_mod,
  output logic [7:0]          dip_sw,
  output logic                core_reset,
  output logic                loaded,
  output logic                err_oob,
  output logic [24:0]         byte_cnt
);

  localparam logic [24:0] MAIN_SIZE = 25'h08000;
  localparam logic [24:0] SND_SIZE  = 25'h01000;
  localparam logic [24:0] WAV_SIZE  = 25'h10000;
  localparam logic [7:0]  IDX_ROM   = 8'd0;
  localparam logic [7:0]  IDX_VAR   = 8'd1;
  localparam logic [7:0]  IDX_DIP   = 8'd254;

  // A one-cycle settle still needs a 1-bit counter holding 0.
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_t;

  // Variant code to one-hot game select; unknown codes fall back to dk.
  function automatic logic [4:0] decode_variant(input logic [7:0] code);
    logic [4:0] onehot;
    case (code)
      8'd0:    onehot = 5'b00001;
      8'd1:    onehot = 5'b00010;
      8'd2:    onehot = 5'b00100;
      8'd3:    onehot = 5'b01000;
      8'd4:    onehot = 5'b10000;
      default: onehot = 5'b00001;
    endcase
    return onehot;
  endfunction

  state_t            state_q;
  state_t            state_d;
  logic              enter_load;
  logic              leave_load;
  logic [CNT_W-1:0]  settle_q;

  logic              rom_start;
  logic              accept;
  logic              in_main;
  logic              in_snd;
  logic              in_wav;
  logic [24:0]       snd_off;
  logic [24:0]       wav_off;

  logic [7:0]        variant_p1;
  logic [7:0]        dip_arr [8];

  assign rom_start = dl.ioctl_download && (dl.ioctl_index == IDX_ROM);

  // ---------------- FSM ----------------
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    leave_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rom_start) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (!dl.ioctl_download) begin
          state_d    = S_SETTLE;
          leave_load = 1'b1;
        end
      end
      S_SETTLE: begin
        // A new ROM download restarts the load even mid-settle.
        if (rom_start) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end else if (settle_q == '0) begin
          state_d = loaded ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        if (rom_start) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      settle_q <= '0;
    end else if (leave_load) begin
      settle_q <= SETTLE_M1;
    end else if ((state_q == S_SETTLE) && (settle_q != '0)) begin
      settle_q <= settle_q - 1'b1;
    end
  end

  // Downloads of any index keep the core parked; the state term keeps it
  // parked until the settle interval has run out.
  always_ff @(posedge clk_sys) begin
    core_reset <= reset | (state_q != S_RUN) | dl.ioctl_download;
  end

  // ---------------- region decode ----------------
  assign accept  = dl.ioctl_wr && (dl.ioctl_index == IDX_ROM) && (state_q == S_LOAD);
  assign snd_off = dl.ioctl_addr - SND_BASE;
  assign wav_off = dl.ioctl_addr - WAV_BASE;
  assign in_main = dl.ioctl_addr < MAIN_SIZE;
  assign in_snd  = (dl.ioctl_addr >= SND_BASE) && (snd_off < SND_SIZE);
  assign in_wav  = (dl.ioctl_addr >= WAV_BASE) && (wav_off < WAV_SIZE);

  // ---------------- write stage (1 cycle) ----------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      main_we  <= 1'b0;
      snd_we   <= 1'b0;
      wav_we   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      byte_cnt <= '0;
      err_oob  <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      main_we <= 1'b0;
      snd_we  <= 1'b0;
      wav_we  <= 1'b0;

      if (enter_load) begin
        byte_cnt <= '0;
        err_oob  <= 1'b0;
        loaded   <= 1'b0;
      end else if (leave_load) begin
        loaded <= (byte_cnt != '0);
      end

      // accept implies LOAD, so it never coincides with the clear above.
      if (accept) begin
        byte_cnt <= byte_cnt + 25'd1;
        wr_data  <= dl.ioctl_dout;
        if (in_main) begin
          wr_addr <= dl.ioctl_addr[15:0];
          main_we <= 1'b1;
        end else if (in_snd) begin
          wr_addr <= snd_off[15:0];
          snd_we  <= 1'b1;
        end else if (in_wav) begin
          wr_addr <= wav_off[15:0];
          wav_we  <= 1'b1;
        end else begin
          wr_addr <= dl.ioctl_addr[15:0];
          err_oob <= 1'b1;
        end
      end
    end
  end

  // ---------------- variant latch / DIP array ----------------
  // These persist across ROM reloads; only reset clears them.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      variant_p1 <= '0;
      game_mod   <= 5'b00001;
      for (int i = 0; i < 8; i++) begin
        dip_arr[i] <= '0;
      end
    end else begin
      if (dl.ioctl_wr && (dl.ioctl_index == IDX_VAR)) begin
        variant_p1 <= dl.ioctl_dout;
      end
      // ---- decode stage: game_mod trails the latch by one cycle ----
      game_mod <= decode_variant(variant_p1);
      if (dl.ioctl_wr && (dl.ioctl_index == IDX_DIP) && (dl.ioctl_addr < 25'd8)) begin
        dip_arr[dl.ioctl_addr[2:0]] <= dl.ioctl_dout;
      end
    end
  end

  assign dip_sw = dip_arr[0];

endmodule
